// File: rtl/pwm_duty_decoder.sv
// Recovers the 3-bit duty code from a PWM line by measuring high time and period.
// One registered strobe per completed period, zero-duty timeout or stuck-high timeout.
module pwm_duty_decoder #(
  parameter int CBITS = 17,
  parameter int SHIFT = CBITS - 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse,
  output logic [2:0] code,
  output logic       valid,
  output logic       locked,
  output logic       period_err
);

  localparam logic [CBITS:0] ZERO  = '0;
  localparam logic [CBITS:0] ONE   = {{CBITS{1'b0}}, 1'b1};
  localparam logic [CBITS:0] FULL  = {1'b1, {CBITS{1'b0}}};
  localparam logic [CBITS:0] ROUND = FULL >> (CBITS - SHIFT + 1);
  localparam logic [CBITS:0] SEVEN = {{(CBITS-2){1'b0}}, 3'd7};

  typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

  state_t         state, state_n;
  logic           pulse_q;
  logic [CBITS:0] high_cnt, per_cnt, low_run;
  logic [CBITS:0] high_n, per_n, low_n;
  logic [CBITS:0] rounded, quot;
  logic [2:0]     code_m, code_n;
  logic           err_n, done;
  logic           rise, fall, low_to, high_to;

  function automatic logic [CBITS:0] inc(input logic [CBITS:0] x);
    return (x == FULL) ? FULL : x + ONE;
  endfunction

  assign rise    = pulse & ~pulse_q;
  assign fall    = ~pulse & pulse_q;
  assign low_to  = (state != HIGH) && (low_run == FULL);
  assign high_to = (state == HIGH) && (high_cnt == FULL);

  // round to nearest code step, saturate at 7
  assign rounded = high_cnt + ROUND;
  assign quot    = rounded >> SHIFT;
  assign code_m  = (quot > SEVEN) ? 3'd7 : quot[2:0];

  always_comb begin
    state_n = state;
    high_n  = high_cnt;
    per_n   = per_cnt;
    low_n   = low_run;
    done    = 1'b0;
    code_n  = code;
    err_n   = period_err;
    case (state)
      SYNC: begin
        if (rise) begin
          state_n = HIGH;
          high_n  = ONE;
          per_n   = ONE;
          low_n   = ZERO;
        end else begin
          low_n = pulse ? ZERO : inc(low_run);
          if (low_to) begin
            done   = 1'b1;
            code_n = 3'd0;
            err_n  = 1'b0;
            low_n  = ONE;
          end
        end
      end
      HIGH: begin
        if (fall) begin
          state_n = LOW;
          per_n   = inc(per_cnt);
          low_n   = ONE;
        end else begin
          high_n = inc(high_cnt);
          per_n  = inc(per_cnt);
        end
        if (high_to) begin
          done   = 1'b1;
          code_n = 3'd7;
          err_n  = 1'b1;
          high_n = ONE;
          per_n  = ONE;
        end
      end
      LOW: begin
        if (rise) begin
          // edge wins over a coincident timeout
          done    = 1'b1;
          code_n  = code_m;
          err_n   = (per_cnt != FULL);
          state_n = HIGH;
          high_n  = ONE;
          per_n   = ONE;
          low_n   = ZERO;
        end else begin
          per_n = inc(per_cnt);
          low_n = inc(low_run);
          if (low_to) begin
            done   = 1'b1;
            code_n = 3'd0;
            err_n  = 1'b0;
            low_n  = ONE;
          end
        end
      end
      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      pulse_q    <= 1'b1;
      high_cnt   <= ZERO;
      per_cnt    <= ZERO;
      low_run    <= ZERO;
      code       <= 3'd0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      period_err <= 1'b0;
    end else begin
      state    <= state_n;
      pulse_q  <= pulse;
      high_cnt <= high_n;
      per_cnt  <= per_n;
      low_run  <= low_n;
      valid    <= done;
      if (done) begin
        code       <= code_n;
        period_err <= err_n;
        locked     <= ~err_n;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder at CBITS=10 (period 1024, code step 128).
module tb_pwm_duty_decoder;
  localparam int CB = 10;
  localparam int SH = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse = 1'b0;
  logic [2:0] code;
  logic       valid, locked, period_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r0 = 0;

  int         vcyc[$];
  logic [2:0] vcode[$];
  logic       vlock[$];
  logic       verr[$];

  pwm_duty_decoder #(.CBITS(CB), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .pulse(pulse),
    .code(code), .valid(valid), .locked(locked), .period_err(period_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcyc.push_back(cyc);
      vcode.push_back(code);
      vlock.push_back(locked);
      verr.push_back(period_err);
    end
  end

  task automatic clear_log();
    vcyc.delete(); vcode.delete(); vlock.delete(); verr.delete();
  endtask

  task automatic drive(input logic v, input int n);
    pulse = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic period(input int h, input int p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  task automatic do_reset(input logic p);
    rst = 1'b1;
    pulse = p;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = cyc;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", code); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", period_err); end
  endtask

  task automatic test_loopback();
    do_reset(1'b1);
    repeat (5) period(384, 1024);
    checks++; if (vcyc.size() != 3) begin errors++; $display("FAIL loop_count got %0d want 3", vcyc.size()); end
    if (vcyc.size() > 0) begin
      checks++; if (vcyc[0] != r0 + 2049) begin errors++; $display("FAIL loop_first_cyc got %0d want %0d", vcyc[0] - r0, 2049); end
      checks++; if (vcode[0] !== 3'd3) begin errors++; $display("FAIL loop_code got %0d want 3", vcode[0]); end
      checks++; if (verr[0] !== 1'b0) begin errors++; $display("FAIL loop_err got %b want 0", verr[0]); end
      checks++; if (vlock[0] !== 1'b1) begin errors++; $display("FAIL loop_lock got %b want 1", vlock[0]); end
    end
    for (int i = 1; i < vcyc.size(); i++) begin
      checks++; if (vcyc[i] - vcyc[i-1] != 1024) begin errors++; $display("FAIL loop_spacing[%0d] got %0d want 1024", i, vcyc[i] - vcyc[i-1]); end
    end
  endtask

  task automatic test_sweep();
    do_reset(1'b0);
    drive(1'b0, 4);
    for (int c = 1; c <= 7; c++) period(c * 128, 1024);
    drive(1'b1, 1);
    drive(1'b0, 3);
    checks++; if (vcyc.size() != 7) begin errors++; $display("FAIL sweep_count got %0d want 7", vcyc.size()); end
    for (int i = 0; i < vcyc.size(); i++) begin
      checks++;
      if (vcode[i] !== 3'(i + 1) || verr[i] !== 1'b0 || vlock[i] !== 1'b1) begin
        errors++;
        $display("FAIL sweep[%0d] got code=%0d err=%b lock=%b want code=%0d err=0 lock=1", i, vcode[i], verr[i], vlock[i], i + 1);
      end
    end
  endtask

  task automatic test_rounding();
    int exp_code[3] = '{4, 3, 5};
    do_reset(1'b0);
    drive(1'b0, 4);
    period(448, 1024);
    period(447, 1024);
    period(640, 1024);
    drive(1'b1, 1);
    drive(1'b0, 3);
    checks++; if (vcyc.size() != 3) begin errors++; $display("FAIL round_count got %0d want 3", vcyc.size()); end
    for (int i = 0; i < vcyc.size() && i < 3; i++) begin
      checks++;
      if (vcode[i] !== 3'(exp_code[i])) begin
        errors++; $display("FAIL round[%0d] got %0d want %0d", i, vcode[i], exp_code[i]);
      end
    end
  endtask

  task automatic test_period_err();
    do_reset(1'b0);
    drive(1'b0, 4);
    period(320, 800);
    period(256, 1024);
    drive(1'b1, 1);
    drive(1'b0, 3);
    checks++; if (vcyc.size() != 2) begin errors++; $display("FAIL perr_count got %0d want 2", vcyc.size()); end
    if (vcyc.size() >= 2) begin
      checks++;
      if (vcode[0] !== 3'd3 || verr[0] !== 1'b1 || vlock[0] !== 1'b0) begin
        errors++; $display("FAIL perr_short got code=%0d err=%b lock=%b want code=3 err=1 lock=0", vcode[0], verr[0], vlock[0]);
      end
      checks++;
      if (vcode[1] !== 3'd2 || verr[1] !== 1'b0 || vlock[1] !== 1'b1) begin
        errors++; $display("FAIL perr_relock got code=%0d err=%b lock=%b want code=2 err=0 lock=1", vcode[1], verr[1], vlock[1]);
      end
    end
  endtask

  task automatic test_zero_duty();
    do_reset(1'b0);
    drive(1'b0, 2100);
    checks++; if (vcyc.size() != 2) begin errors++; $display("FAIL zero_count got %0d want 2", vcyc.size()); end
    if (vcyc.size() >= 2) begin
      checks++; if (vcyc[0] != r0 + 1025) begin errors++; $display("FAIL zero_first_cyc got %0d want 1025", vcyc[0] - r0); end
      checks++; if (vcyc[1] != r0 + 2049) begin errors++; $display("FAIL zero_second_cyc got %0d want 2049", vcyc[1] - r0); end
      checks++;
      if (vcode[0] !== 3'd0 || vlock[0] !== 1'b1 || verr[0] !== 1'b0) begin
        errors++; $display("FAIL zero_fields got code=%0d lock=%b err=%b want code=0 lock=1 err=0", vcode[0], vlock[0], verr[0]);
      end
    end
  endtask

  task automatic test_stuck_high();
    int x;
    do_reset(1'b1);
    drive(1'b1, 2000);
    checks++; if (vcyc.size() != 0) begin errors++; $display("FAIL stuck_sync_count got %0d want 0", vcyc.size()); end
    drive(1'b0, 1);
    x = cyc;
    drive(1'b1, 1100);
    checks++; if (vcyc.size() != 1) begin errors++; $display("FAIL stuck_count got %0d want 1", vcyc.size()); end
    if (vcyc.size() >= 1) begin
      checks++; if (vcyc[0] != x + 1025) begin errors++; $display("FAIL stuck_cyc got %0d want 1024 after edge", vcyc[0] - x - 1); end
      checks++;
      if (vcode[0] !== 3'd7 || verr[0] !== 1'b1 || vlock[0] !== 1'b0) begin
        errors++; $display("FAIL stuck_fields got code=%0d err=%b lock=%b want code=7 err=1 lock=0", vcode[0], verr[0], vlock[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    drive(1'b0, 4);
    period(384, 1024);
    period(384, 1024);
    drive(1'b1, 100);
    checks++;
    if (code !== 3'd3 || locked !== 1'b1) begin
      errors++; $display("FAIL mid_pre got code=%0d lock=%b want code=3 lock=1", code, locked);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (code !== 3'd0 || valid !== 1'b0 || locked !== 1'b0 || period_err !== 1'b0) begin
      errors++; $display("FAIL mid_rst got code=%0d valid=%b lock=%b err=%b want all 0", code, valid, locked, period_err);
    end
    rst = 1'b0;
    clear_log();
    drive(1'b1, 284);
    drive(1'b0, 640);
    period(384, 1024);
    checks++; if (vcyc.size() != 0) begin errors++; $display("FAIL mid_quiet got %0d strobes want 0", vcyc.size()); end
    drive(1'b1, 1);
    drive(1'b0, 3);
    checks++; if (vcyc.size() != 1) begin errors++; $display("FAIL mid_resume_count got %0d want 1", vcyc.size()); end
    if (vcyc.size() >= 1) begin
      checks++;
      if (vcode[0] !== 3'd3 || vlock[0] !== 1'b1) begin
        errors++; $display("FAIL mid_resume got code=%0d lock=%b want code=3 lock=1", vcode[0], vlock[0]);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_loopback();
    test_sweep();
    test_rounding();
    test_period_err();
    test_zero_duty();
    test_stuck_high();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
